sort4_frame_feeder: RTL

Serial-to-parallel front end for the 4-input pipelined sorter.
- Accepts a stream of w-bit samples with a valid/ready handshake.
- Packs each group of four samples into one frame on the sorter's a, b, c, d inputs and pulses frame_valid.
- Carries a latency-matched valid flag (sorted_valid) that lines up with the sorter's min/midl/midh/max outputs.
- Supports partial-frame flush with padding and downstream hold (back-pressure).

---
 rtl/sort4_frame_feeder_pkg.sv | 6 +
 rtl/sort4_frame_feeder_valid_delay_line.sv | 16 +
 rtl/sort4_frame_feeder.sv | 90 +++++++++
 3 files changed

// File: rtl/sort4_frame_feeder_pkg.sv
// sort4_frame_feeder_pkg: shared types and constants for the sorter front end
package sort4_frame_feeder_pkg;
  typedef enum logic {FILL, WAIT} state_t;
  localparam int SLOTS = 4;
  localparam int CNT_W = 8;
endpackage

// File: rtl/sort4_frame_feeder_valid_delay_line.sv
// valid_delay_line: LAT-deep 1-bit shift register with async reset
module valid_delay_line #(
  parameter int LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [LAT-1:0] r_sh;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sh <= '0;
    else r_sh <= LAT'({r_sh, d});
  end
  assign q = r_sh[LAT-1];
endmodule

// File: rtl/sort4_frame_feeder.sv
// sort4_frame_feeder: packs a sample stream into 4-slot frames for the pipelined sorter
module sort4_frame_feeder
  import sort4_frame_feeder_pkg::*;
#(
  parameter int w = 6,
  parameter int LAT = 4,
  parameter logic [w-1:0] PAD = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [w-1:0]     samp_in,
  input  logic             samp_valid,
  output logic             samp_ready,
  input  logic             flush,
  input  logic             hold,
  output logic [w-1:0]     a,
  output logic [w-1:0]     b,
  output logic [w-1:0]     c,
  output logic [w-1:0]     d,
  output logic             frame_valid,
  output logic             sorted_valid,
  output logic [CNT_W-1:0] frame_cnt
);
  state_t           r_state;
  logic [1:0]       r_idx;
  logic [w-1:0]     r_stg [SLOTS];
  logic [w-1:0]     r_out [SLOTS];
  logic             r_fv;
  logic [CNT_W-1:0] r_cnt;
  logic             w_acc;
  logic             w_flush;
  logic             w_done;
  logic [2:0]       w_fill;
  logic [w-1:0]     w_stg [SLOTS];
  assign samp_ready = ~rst & (r_state == FILL);
  assign w_acc = samp_valid & samp_ready;
  assign w_fill = {1'b0, r_idx} + {2'b0, w_acc};
  // a flush right behind a frame waits a cycle so frame_valid never pulses back to back
  assign w_flush = flush & ~r_fv;
  assign w_done = (r_state == FILL) & (w_fill[2] | (w_flush & (w_fill != 3'd0)));
  always_comb begin
    for (int i = 0; i < SLOTS; i++)
      w_stg[i] = (w_acc && r_idx == 2'(i)) ? samp_in : (3'(i) < w_fill) ? r_stg[i] : PAD;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FILL;
      r_idx   <= '0;
      r_stg   <= '{default: '0};
      r_out   <= '{default: '0};
      r_fv    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_fv <= 1'b0;
      if (r_state == WAIT) begin
        if (!hold) begin
          r_out   <= r_stg;
          r_fv    <= 1'b1;
          r_cnt   <= r_cnt + 1'b1;
          r_state <= FILL;
        end
      end else if (w_done) begin
        r_idx <= '0;
        if (hold) begin
          r_stg   <= w_stg;
          r_state <= WAIT;
        end else begin
          r_out <= w_stg;
          r_fv  <= 1'b1;
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_stg <= w_stg;
        if (w_acc) r_idx <= r_idx + 2'd1;
      end
    end
  end
  assign a = r_out[0];
  assign b = r_out[1];
  assign c = r_out[2];
  assign d = r_out[3];
  assign frame_valid = r_fv;
  assign frame_cnt = r_cnt;
  valid_delay_line #(.LAT(LAT)) u_dly (
    .clk(clk),
    .rst(rst),
    .d  (r_fv),
    .q  (sorted_valid)
  );
endmodule
